sensor_scan_debounce: RTL and testbench

Downstream consumer of the cyclic active-low LED/sensor select strobe. Samples the shared sensor return line in the time slot of each of the 4 channels and runs a per-channel consecutive-sample debounce. Publishes stable key states plus one-cycle press and release pulses to the application logic. Detects select codes that are not active-low one-hot and flags them.

---
 rtl/sensor_scan_pkg.sv | 39 +++
 rtl/debounce_ch.sv | 58 +++++
 rtl/sensor_scan_debounce.sv | 82 ++++++++
 tb/tb_sensor_scan_debounce.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_scan_pkg.sv
// Definitions shared between the scan cycler and the sensor debounce block:
// channel count, active-low one-hot select codes and the select decoder.
package sensor_scan_pkg;

    localparam int NUM_CH = 4;

    localparam logic [3:0] SEL_CH0  = 4'b1110;
    localparam logic [3:0] SEL_CH1  = 4'b1101;
    localparam logic [3:0] SEL_CH2  = 4'b1011;
    localparam logic [3:0] SEL_CH3  = 4'b0111;
    localparam logic [3:0] SEL_IDLE = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } sel_dec_t;

    // Map a select code to its channel index; valid is low for anything
    // that is not one of the four legal codes (idle included).
    function automatic sel_dec_t sel_to_idx(input logic [3:0] sel);
        sel_dec_t d;
        d.valid = 1'b1;
        d.idx   = 2'd0;
        case (sel)
            SEL_CH0: d.idx = 2'd0;
            SEL_CH1: d.idx = 2'd1;
            SEL_CH2: d.idx = 2'd2;
            SEL_CH3: d.idx = 2'd3;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Debounce counter width: ceil(log2(deb)), never below one bit.
    function automatic int cnt_width(input int deb);
        return (deb > 1) ? $clog2(deb) : 1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single-channel debounce: counts consecutive samples that disagree with the
// stable state and flips the state once DEB_CNT of them have been seen.
module debounce_ch
    import sensor_scan_pkg::*;
#(
    parameter int DEB_CNT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic raw,
    output logic state,
    output logic state_nxt,
    output logic press,
    output logic release_evt
);

    localparam int             CW   = cnt_width(DEB_CNT);
    localparam logic [CW-1:0]  LAST = CW'(DEB_CNT - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          flip;

    // Next counter/state for this channel; only an addressed sample moves them.
    always_comb begin
        cnt_nxt   = cnt;
        state_nxt = state;
        flip      = 1'b0;
        if (sample_en) begin
            if (raw == state) begin
                cnt_nxt = '0;
            end else if (cnt == LAST) begin
                state_nxt = ~state;
                cnt_nxt   = '0;
                flip      = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // Register state, counter and the edge pulses (pulse lines up with the new state).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            state       <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            state       <= state_nxt;
            press       <= flip & ~state;
            release_evt <= flip & state;
        end
    end

endmodule

// File: rtl/sensor_scan_debounce.sv
// Samples the shared sensor line in each channel's scan slot, debounces the
// four channels independently and flags select codes that are not legal.
module sensor_scan_debounce
    import sensor_scan_pkg::*;
#(
    parameter int DEB_CNT          = 8,
    parameter bit SENSE_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        i_scan_sel,
    input  logic              i_sense,
    output logic [NUM_CH-1:0] o_key_state,
    output logic [NUM_CH-1:0] o_key_press,
    output logic [NUM_CH-1:0] o_key_release,
    output logic              o_any_key,
    output logic              o_scan_err
);

    logic              sense_meta;
    logic              sense_sync;
    logic [3:0]        sel_d1;
    logic [3:0]        sel_d2;
    sel_dec_t          dec;
    logic              raw;
    logic [NUM_CH-1:0] sample_en;
    logic [NUM_CH-1:0] state_nxt;
    logic              scan_err_nxt;

    // Synchronise the sense line and delay the select by the same two cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sense_meta <= 1'b0;
            sense_sync <= 1'b0;
            sel_d1     <= SEL_IDLE;
            sel_d2     <= SEL_IDLE;
        end else begin
            sense_meta <= i_sense;
            sense_sync <= sense_meta;
            sel_d1     <= i_scan_sel;
            sel_d2     <= sel_d1;
        end
    end

    // Decode the aligned select into a per-channel sample strobe and an error flag.
    always_comb begin
        dec          = sel_to_idx(sel_d2);
        raw          = SENSE_ACTIVE_LOW ? ~sense_sync : sense_sync;
        sample_en    = '0;
        if (dec.valid) begin
            sample_en[dec.idx] = 1'b1;
        end
        scan_err_nxt = !dec.valid && (sel_d2 != SEL_IDLE);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_ch #(
            .DEB_CNT(DEB_CNT)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sample_en  (sample_en[g]),
            .raw        (raw),
            .state      (o_key_state[g]),
            .state_nxt  (state_nxt[g]),
            .press      (o_key_press[g]),
            .release_evt(o_key_release[g])
        );
    end

    // Register any-key alongside the channel states, and the scan error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_any_key  <= 1'b0;
            o_scan_err <= 1'b0;
        end else begin
            o_any_key  <= |state_nxt;
            o_scan_err <= scan_err_nxt;
        end
    end

endmodule

// File: tb/tb_sensor_scan_debounce.sv
// Self-checking bench: a default build (DEB_CNT=8, active-low sense) and a
// DEB_CNT=1 active-high build share clock, reset and select; each has its
// own sense line. A behavioural model is compared after every clock.
module tb_sensor_scan_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] scan_sel;
    logic       sense0;
    logic       sense1;

    logic [3:0] state0, press0, rel0, state1, press1, rel1;
    logic       any0, err0, any1, err1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    sensor_scan_debounce #(.DEB_CNT(8), .SENSE_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_scan_sel(scan_sel), .i_sense(sense0),
        .o_key_state(state0), .o_key_press(press0), .o_key_release(rel0),
        .o_any_key(any0), .o_scan_err(err0)
    );

    sensor_scan_debounce #(.DEB_CNT(1), .SENSE_ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_scan_sel(scan_sel), .i_sense(sense1),
        .o_key_state(state1), .o_key_press(press1), .o_key_release(rel1),
        .o_any_key(any1), .o_scan_err(err1)
    );

    // Behavioural model: inputs seen two clocks ago, plus per-channel stable
    // state and the length of the current run of disagreeing samples.
    int         modelD[2]   = '{8, 1};
    bit         actLow[2]   = '{1'b1, 1'b0};
    logic [3:0] pSel[2];
    logic       pSense[2][2];
    logic [3:0] mState[2];
    logic [3:0] mPress[2];
    logic [3:0] mRel[2];
    logic       mErr[2];
    int         mRun[2][4];

    function automatic logic [3:0] code(input int c);
        logic [3:0] v;
        v = 4'b0001 << c;
        return ~v;
    endfunction

    task automatic modelStep(input logic r, input logic [3:0] sel, input logic s0, input logic s1);
        logic [3:0] aSel;
        logic       aSense;
        logic       touched;
        int         ch;
        aSel = pSel[1];
        for (int m = 0; m < 2; m++) begin
            mPress[m] = 4'b0;
            mRel[m]   = 4'b0;
            mErr[m]   = 1'b0;
            if (!r) begin
                mState[m] = 4'b0;
                for (int c = 0; c < 4; c++) mRun[m][c] = 0;
            end else begin
                aSense  = pSense[m][1];
                touched = actLow[m] ? !aSense : aSense;
                ch = -1;
                for (int c = 0; c < 4; c++) if (aSel == code(c)) ch = c;
                if (ch >= 0) begin
                    if (touched != mState[m][ch]) begin
                        mRun[m][ch] = mRun[m][ch] + 1;
                        if (mRun[m][ch] == modelD[m]) begin
                            mState[m][ch] = touched;
                            if (touched) mPress[m][ch] = 1'b1;
                            else         mRel[m][ch]   = 1'b1;
                            mRun[m][ch] = 0;
                        end
                    end else begin
                        mRun[m][ch] = 0;
                    end
                end else if (aSel != 4'hF) begin
                    mErr[m] = 1'b1;
                end
            end
        end
        if (!r) begin
            pSel[0] = 4'hF; pSel[1] = 4'hF;
            for (int m = 0; m < 2; m++) begin
                pSense[m][0] = 1'b0; pSense[m][1] = 1'b0;
            end
        end else begin
            pSel[1] = pSel[0]; pSel[0] = sel;
            pSense[0][1] = pSense[0][0]; pSense[0][0] = s0;
            pSense[1][1] = pSense[1][0]; pSense[1][0] = s1;
        end
    endtask

    task automatic checkVal(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [13:0] got0, exp0, got1, exp1;
        got0 = {state0, press0, rel0, any0, err0};
        exp0 = {mState[0], mPress[0], mRel[0], |mState[0], mErr[0]};
        got1 = {state1, press1, rel1, any1, err1};
        exp1 = {mState[1], mPress[1], mRel[1], |mState[1], mErr[1]};
        checks++;
        if (got0 !== exp0) begin
            errors++;
            $display("[TB] FAIL model_dut0 (cycle %0d): got st/pr/rl/any/err=%b/%b/%b/%b/%b, expected %b/%b/%b/%b/%b",
                     cyc, state0, press0, rel0, any0, err0, mState[0], mPress[0], mRel[0], |mState[0], mErr[0]);
        end
        checks++;
        if (got1 !== exp1) begin
            errors++;
            $display("[TB] FAIL model_dut1 (cycle %0d): got st/pr/rl/any/err=%b/%b/%b/%b/%b, expected %b/%b/%b/%b/%b",
                     cyc, state1, press1, rel1, any1, err1, mState[1], mPress[1], mRel[1], |mState[1], mErr[1]);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] sel, input logic s0, input logic s1);
        rst_n    = r;
        scan_sel = sel;
        sense0   = s0;
        sense1   = s1;
        @(posedge clk);
        modelStep(r, sel, s0, s1);
        #2;
        checkOutput();
        cyc++;
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'hF, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic [3:0] sel;
        logic       expErr;
        logic [3:0] expState;
    } vec_t;

    vec_t tbl[8];

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int firstPress[4];
        int firstRel;
        int cnt;
        int other;
        int ptr;
        int ch;
        int rnd;
        logic [3:0] sel;
        logic [3:0] touch0, touch1;
        logic s0, s1, r;

        // Illegal/idle select table: error shows two rows after each illegal code.
        tbl[0] = '{4'hF,    1'b0, 4'b0000};
        tbl[1] = '{4'hF,    1'b0, 4'b0000};
        tbl[2] = '{4'b1100, 1'b0, 4'b0000};
        tbl[3] = '{4'b0000, 1'b0, 4'b0000};
        tbl[4] = '{4'hF,    1'b1, 4'b0000};
        tbl[5] = '{4'hF,    1'b1, 4'b0000};
        tbl[6] = '{4'hF,    1'b0, 4'b0000};
        tbl[7] = '{4'hF,    1'b0, 4'b0000};

        // Reset held while scanning with every channel touched.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, code(i % 4), 1'b0, 1'b0);
        checkVal("reset_outputs_zero", int'({state0, press0, rel0, any0, err0}), 0);
        for (int n = 0; n < 4; n++) firstPress[n] = -1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, code(i % 4), 1'b0, 1'b0);
            for (int n = 0; n < 4; n++) if (press0[n] && firstPress[n] < 0) firstPress[n] = i;
        end
        for (int n = 0; n < 4; n++) checkVal($sformatf("ch%0d_press_latency", n), firstPress[n], n + 30);
        checkVal("all_touched_state", int'(state0), 15);

        // Single press then release on channel 2.
        doReset(2);
        cnt = 0; other = 0; firstPress[2] = -1;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, code(i % 4), (i % 4 == 2) ? 1'b0 : 1'b1, 1'b0);
            cnt += int'(press0[2]);
            other |= int'(press0 & 4'b1011) | int'(rel0);
            if (press0[2] && firstPress[2] < 0) firstPress[2] = i;
        end
        checkVal("ch2_press_count", cnt, 1);
        checkVal("ch2_press_row", firstPress[2], 32);
        checkVal("ch2_other_pulses", other, 0);
        checkVal("ch2_state", int'(state0), 4);
        checkVal("ch2_any", int'(any0), 1);
        cnt = 0; firstRel = -1;
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'b1, code(i % 4), 1'b1, 1'b0);
            cnt += int'(rel0[2]);
            if (rel0[2] && firstRel < 0) firstRel = i;
        end
        checkVal("ch2_release_count", cnt, 1);
        checkVal("ch2_release_row", firstRel, 32);
        checkVal("ch2_released_state", int'({state0, any0}), 0);

        // Glitch: two bursts of 7 touches on ch1 separated by a release.
        doReset(2);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, code(i % 4), ((i % 4 == 1) && (i < 28 || i >= 36)) ? 1'b0 : 1'b1, 1'b0);
            cnt += int'(|{press0, rel0});
        end
        checkVal("glitch_pulses", cnt, 0);
        checkVal("glitch_state", int'(state0), 0);

        // Illegal and idle select codes.
        doReset(2);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, tbl[i].sel, 1'b1, 1'b0);
            checkVal($sformatf("tbl%0d_scan_err", i), int'(err0), int'(tbl[i].expErr));
            checkVal($sformatf("tbl%0d_state", i), int'(state0), int'(tbl[i].expState));
            cnt += int'(err0);
        end
        checkVal("scan_err_pulse_count", cnt, 2);

        // Reset in the middle of a ch3 debounce.
        doReset(2);
        for (int i = 0; i < 22; i++) applyStimulus(1'b1, code(i % 4), (i % 4 == 3) ? 1'b0 : 1'b1, 1'b0);
        applyStimulus(1'b0, code(2), 1'b0, 1'b0);
        checkVal("mid_reset_state", int'(state0), 0);
        firstPress[3] = -1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, code(i % 4), (i % 4 == 3) ? 1'b0 : 1'b1, 1'b0);
            if (press0[3] && firstPress[3] < 0) firstPress[3] = i;
        end
        checkVal("ch3_fresh_press_row", firstPress[3], 33);

        // DEB_CNT=1 active-high build: one ch0 touch slot at row 4.
        doReset(2);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, code(i % 4), 1'b1, (i == 4) ? 1'b1 : 1'b0);
            if (i == 5) checkVal("d1_state_row5", int'(state1), 0);
            if (i == 6) begin
                checkVal("d1_state_row6", int'(state1), 1);
                checkVal("d1_press_row6", int'(press1), 1);
            end
            if (i == 7) begin
                checkVal("d1_state_row7", int'(state1), 1);
                checkVal("d1_press_row7", int'(press1), 0);
            end
            if (i == 10) begin
                checkVal("d1_state_row10", int'(state1), 0);
                checkVal("d1_release_row10", int'(rel1), 1);
            end
        end

        // Randomised traffic against the model.
        doReset(2);
        ptr = 0; touch0 = 4'b0; touch1 = 4'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) touch0[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) touch1[$urandom_range(0, 3)] ^= 1'b1;
            rnd = int'($urandom_range(0, 19));
            ch = -1;
            if (rnd < 16) begin
                ch  = ptr;
                sel = code(ptr);
                ptr = (ptr + 1) % 4;
            end else if (rnd < 18) begin
                sel = 4'hF;
            end else begin
                sel = 4'($urandom_range(0, 15));
            end
            if (ch >= 0) begin
                s0 = !touch0[ch];
                s1 = touch1[ch];
            end else begin
                s0 = 1'($urandom_range(0, 1));
                s1 = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 15) == 0) s0 = !s0;
            if ($urandom_range(0, 15) == 0) s1 = !s1;
            r = ($urandom_range(0, 599) != 0);
            applyStimulus(r, sel, s0, s1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
